// File: rtl/ff256_ct_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ff256_ct_seq_pkg
//  Purpose  : Shared types and constants for the sequential 8-point FF256
//             cosine-transform controller.
//  Contents : N / W / ROW_W sizing constants, LAST_ROW, FSM state enum,
//             GF(256) XOR-reduction helper (GF(256) addition is bitwise XOR).
//  Revision : 1.0 - initial release
// ============================================================================
package ff256_ct_seq_pkg;

    // Vector length and symbol width are fixed at 8; other values are unsupported.
    localparam int N     = 8;
    localparam int W     = 8;
    localparam int ROW_W = $clog2(N);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } ct_state_e;

    // Sum of N GF(256) symbols: plain XOR, no carries, result stays W bits.
    function automatic logic [W-1:0] ff256_xor_reduce(input logic [N*W-1:0] vec);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc ^ vec[k*W +: W];
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff256_xor_reduce_8.sv
`default_nettype none
// ============================================================================
//  Module   : ff256_xor_reduce_8
//  Purpose  : Combinational XOR tree folding eight GF(256) products into one
//             symbol. Kept standalone so a parallel datapath can reuse it.
//  Ports    : bytes_in [N*W-1:0]  eight products, byte k at [8k+7:8k]
//             xor_out  [W-1:0]    GF(256) sum of the eight products
//  Revision : 1.0 - initial release
// ============================================================================
module ff256_xor_reduce_8
    import ff256_ct_seq_pkg::*;
(
    input  logic [N*W-1:0] bytes_in,
    output logic [W-1:0]   xor_out
);

    assign xor_out = ff256_xor_reduce(bytes_in);

endmodule
`default_nettype wire

// File: rtl/ff256_ct_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ff256_ct_seq_controller
//  Purpose  : Sequencer for the sequential 8-point FF256 cosine transform.
//             Captures one input vector, steps the external multiplier bank
//             through rows 0..7 (one per cycle), XOR-reduces each row's
//             products into output symbol n and presents the result vector.
//  Ports    : clk, rst_n            clock / async active-low reset
//             in_valid/in_ready     input vector handshake, in_data [63:0]
//             mult_row_sel [2:0]    row select to the multiplier mux
//             mult_x_in   [63:0]    held input vector to all multipliers
//             mult_x_out  [63:0]    products of the selected row
//             out_valid/out_ready   result handshake, out_data [63:0]
//             busy                  high while computing or holding a result
//  Revision : 1.0 - initial release
// ============================================================================
module ff256_ct_seq_controller
    import ff256_ct_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic [ROW_W-1:0] mult_row_sel,
    output logic [N*W-1:0]   mult_x_in,
    input  logic [N*W-1:0]   mult_x_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_data,
    output logic             busy
);

    ct_state_e        r_state;
    ct_state_e        w_state_nxt;
    logic [ROW_W-1:0] r_row;
    logic [N*W-1:0]   r_x;
    logic [N*W-1:0]   r_result;
    logic [W-1:0]     w_row_sum;
    logic             w_accept;

    ff256_xor_reduce_8 u_xor_reduce (
        .bytes_in (mult_x_out),
        .xor_out  (w_row_sum)
    );

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (r_row == LAST_ROW) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // A new vector may be taken in the same cycle the result leaves.
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? COMPUTE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Input register and row counter. The counter holds at LAST_ROW and is
    // only cleared by the next accept, so the row select never leaves 0..N-1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_x   <= in_data;
            r_row <= '0;
        end else if (r_state == COMPUTE && r_row != LAST_ROW) begin
            r_row <= r_row + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result register: symbol n is written only while computing row n, so
    // a result held in DONE is untouched until the next vector is computing,
    // which is after its output handshake.
    // ------------------------------------------------------------------
    for (genvar n = 0; n < N; n++) begin : g_result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_result[n*W +: W] <= '0;
            end else if (r_state == COMPUTE && r_row == ROW_W'(n)) begin
                r_result[n*W +: W] <= w_row_sum;
            end
        end
    end

    assign mult_row_sel = r_row;
    assign mult_x_in    = r_x;
    assign out_data     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ff256_ct_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ff256_ct_seq_controller
//  Purpose  : Self-checking bench for ff256_ct_seq_controller. A bench-side
//             multiplier stub (bypass, row-tag or GF(256) matrix) closes the
//             loop; expected results are queued at each input handshake and
//             compared at each output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ff256_ct_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [2:0]  mult_row_sel;
    logic [63:0] mult_x_in;
    logic [63:0] mult_x_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int          mode;        // 0 bypass, 1 row-tag, 2 GF(256) matrix
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_out    = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    ff256_ct_seq_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mult_row_sel (mult_row_sel),
        .mult_x_in    (mult_x_in),
        .mult_x_out   (mult_x_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    // GF(256) multiply, reduction polynomial x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int n, input int k);
        int c;
        c = (n * 8 + k) * 29 + 7;
        return c[7:0];
    endfunction

    // Multiplier-bank stub: combinational products of the selected row.
    always_comb begin
        mult_x_out = '0;
        case (mode)
            0: mult_x_out = mult_x_in;
            1: mult_x_out = {56'h0, 5'h0, mult_row_sel};
            default: begin
                for (int k = 0; k < 8; k++) begin
                    mult_x_out[k*8 +: 8] = gfmul(coef(int'(mult_row_sel), k), mult_x_in[k*8 +: 8]);
                end
            end
        endcase
    end

    // Reference: full matrix-vector product for the current stub.
    function automatic logic [63:0] model(input logic [63:0] x, input int md);
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            s = 8'h00;
            for (int k = 0; k < 8; k++) begin
                case (md)
                    0:       s = s ^ x[k*8 +: 8];
                    1:       s = s ^ ((k == 0) ? 8'(n) : 8'h00);
                    default: s = s ^ gfmul(coef(n, k), x[k*8 +: 8]);
                endcase
            end
            r[n*8 +: 8] = s;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a falling edge: record handshakes that the
    // next rising edge will take, then advance to the next falling edge.
    task automatic tick();
        if (in_valid && in_ready) sb.push_back(model(in_data, mode));
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) chk("unexpected_output", 64'(sb.size()), 64'd1);
            else                chk("out_data", out_data, sb.pop_front());
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            #1;
            tick();
            t++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] vecs[4];
        logic [63:0] held;
        int          oc[$];
        int          idx;
        int          seen;
        int          t;
        logic        acc;

        mode      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_row_sel", 64'(mult_row_sel), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_x_in", mult_x_in, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---- abort mid-COMPUTE at row 4 -------------------------------
        in_valid = 1'b1;
        in_data  = 64'h1122334455667788;
        tick();
        in_valid = 1'b0;
        repeat (4) begin #1; tick(); end
        #1;
        chk("abort_row_before", 64'(mult_row_sel), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_row_sel", 64'(mult_row_sel), 64'd0);
        chk("abort_x_in", mult_x_in, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (15) begin
            if (out_valid) seen = 1;
            tick();
            #1;
        end
        chk("abort_no_output", 64'(seen), 64'd0);

        // ---- bypass: latency and row sequence ---------------------------
        in_valid = 1'b1;
        in_data  = 64'h8040201008040201;
        chk("bypass_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("bypass_row_c%0d", c), 64'(mult_row_sel), 64'(c - 1));
            chk($sformatf("bypass_nvalid_c%0d", c), 64'(out_valid), 64'd0);
            chk($sformatf("bypass_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("bypass_inrdy_c%0d", c), 64'(in_ready), 64'd0);
            tick();
        end
        #1;
        chk("bypass_valid_c9", 64'(out_valid), 64'd1);
        chk("bypass_x_in", mult_x_in, 64'h8040201008040201);
        chk("bypass_result", out_data, 64'hFFFFFFFFFFFFFFFF);
        tick();

        // ---- row-tag stub -----------------------------------------------
        mode     = 1;
        in_valid = 1'b1;
        in_data  = 64'hDEADBEEFCAFEF00D;
        #1;
        tick();
        in_valid = 1'b0;
        drain(20);
        chk("rowtag_last", out_data, 64'h0706050403020100);

        // ---- backpressure ----------------------------------------------
        mode      = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0000000000000003;
        #1;
        tick();
        in_valid = 1'b0;
        t = 0;
        #1;
        while (!out_valid && t < 20) begin tick(); #1; t++; end
        chk("bp_reach_done", 64'(out_valid), 64'd1);
        held     = out_data;
        chk("bp_held_value", held, 64'h0303030303030303);
        in_valid = 1'b1;
        in_data  = 64'h1;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_stable", out_data, held);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        drain(20);
        chk("bp_pending_result", out_data, 64'h0101010101010101);

        // ---- back-to-back ----------------------------------------------
        vecs[0]  = 64'h01;
        vecs[1]  = 64'h0303;
        vecs[2]  = 64'h070707;
        vecs[3]  = 64'h0F0F0F0F;
        idx      = 0;
        n_out    = 0;
        in_valid = 1'b1;
        in_data  = vecs[0];
        t        = 0;
        while ((idx < 4 || sb.size() != 0) && t < 60) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) oc.push_back(cyc);
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) in_data = vecs[idx];
                else         in_valid = 1'b0;
            end
            t++;
        end
        chk("b2b_count", 64'(oc.size()), 64'd4);
        for (int i = 0; i + 1 < oc.size(); i++) begin
            chk($sformatf("b2b_spacing_%0d", i), 64'(oc[i+1] - oc[i]), 64'd9);
        end

        // ---- GF(256) matrix stub, random vectors and stalls ---------------
        mode     = 2;
        idx      = 0;
        n_out    = 0;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        t        = 0;
        while ((idx < 1000 || sb.size() != 0) && t < 30000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 1000) in_data = {$urandom, $urandom};
                else            in_valid = 1'b0;
            end
            t++;
        end
        chk("matrix_outputs", 64'(n_out), 64'd1000);
        chk("matrix_queue_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
